// File: rtl/maze_pkg.sv
// Shared definitions for the maze cell memory subsystem.
//   ADDR_W / DATA_W : cell memory geometry (8x8 maze, 2-bit cells)
//   CELL_*          : cell codes stored in the memory
//   bus_state_e     : memory bus phase used by the arbiter FSM
package maze_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 2;

  localparam logic [DATA_W-1:0] CELL_PATH = 2'd0;
  localparam logic [DATA_W-1:0] CELL_WALL = 2'd1;
  localparam logic [DATA_W-1:0] CELL_GOAL = 2'd2;

  localparam logic MEM_CMD_READ  = 1'b1;
  localparam logic MEM_CMD_WRITE = 1'b0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StTurn  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/maze_rr_arb2.sv
// Two-way arbiter for the maze memory.
//   FIXED_PRIO=0 : round-robin, on a tie the port not granted last wins
//   FIXED_PRIO=1 : port 0 always wins a tie
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : grants allowed this cycle
//   req0, req1  : request lines
//   gnt0, gnt1  : one-hot (or zero) grant, combinational
module maze_rr_arb2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // rr_last: 0 = port 0 granted last, 1 = port 1 granted last.
  logic rr_last_q, rr_last_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        if ((FIXED_PRIO != 0) || rr_last_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt0) begin
      rr_last_d = 1'b0;
    end else if (gnt1) begin
      rr_last_d = 1'b1;
    end
  end

  // Reset to "port 1 last" so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Shares the single-port maze cell memory between the display scan (port 0, read
// only) and the game logic (port 1, read/write).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   p0_valid/p0_addr/p0_ready       : port 0 read request handshake
//   p0_rvalid/p0_rdata              : port 0 read return (one cycle after grant)
//   p1_valid/p1_we/p1_addr/p1_wdata : port 1 request
//   p1_ready, p1_rvalid/p1_rdata    : port 1 handshake and read return
//   mem_address/mem_command         : memory address, 1=read 0=write
//   mem_data                        : bidirectional memory data bus
// A grant happens in the same cycle as the bus access. A granted write makes the
// current cycle the WRITE phase (we drive the bus, the memory commits at the edge),
// followed by one TURN cycle with no grants so the bus is released before the next
// memory-driven read.
module maze_mem_arbiter #(
  parameter int unsigned ADDR_W     = maze_pkg::ADDR_W,
  parameter int unsigned DATA_W     = maze_pkg::DATA_W,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_command,
  inout  wire  [DATA_W-1:0] mem_data
);

  import maze_pkg::*;

  bus_state_e state_q, state_d, phase;

  logic              arb_en;
  logic              gnt0, gnt1;
  logic              wr_go;
  logic              mem_oe;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Gating with rst_n releases the bus and drops grants asynchronously on reset.
  assign arb_en = rst_n && (state_q == StIdle);

  maze_rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (arb_en),
    .req0 (p0_valid),
    .req1 (p1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign p0_ready = gnt0;
  assign p1_ready = gnt1;
  assign wr_go    = gnt1 && p1_we;

  // The WRITE phase is the write grant cycle itself, so it is derived from the
  // registered state plus the live grant rather than held in a flop.
  always_comb begin
    phase = state_q;
    if ((state_q == StIdle) && wr_go) begin
      phase = StWrite;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (phase)
      StIdle:  state_d = StIdle;
      StWrite: state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_oe      = (phase == StWrite);
  assign mem_command = mem_oe ? MEM_CMD_WRITE : MEM_CMD_READ;
  assign mem_data    = mem_oe ? p1_wdata : {DATA_W{1'bz}};

  // Address follows the grant in the grant cycle and holds when the bus is idle.
  always_comb begin
    addr_d = addr_q;
    if (gnt0) begin
      addr_d = p0_addr;
    end else if (gnt1) begin
      addr_d = p1_addr;
    end
  end

  assign mem_address = addr_d;

  always_comb begin
    rvalid0_d = gnt0;
    rdata0_d  = rdata0_q;
    if (gnt0) begin
      rdata0_d = mem_data;
    end
    rvalid1_d = gnt1 && !p1_we;
    rdata1_d  = rdata1_q;
    if (gnt1 && !p1_we) begin
      rdata1_d = mem_data;
    end
  end

  assign p0_rvalid = rvalid0_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rvalid = rvalid1_q;
  assign p1_rdata  = rdata1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= CELL_PATH;
      rdata1_q  <= CELL_PATH;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed scenarios followed by randomized traffic,
// checked against a cycle-level reference of the arbitration and memory contents.
module tb_maze_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  logic       p0_valid, p1_valid, p1_we;
  logic [5:0] p0_addr, p1_addr;
  logic [1:0] p1_wdata;

  logic       p0_ready, p0_rvalid, p1_ready, p1_rvalid, mem_command;
  logic [1:0] p0_rdata, p1_rdata;
  logic [5:0] mem_address;
  wire  [1:0] mem_data;

  logic       f_p0_ready, f_p0_rvalid, f_p1_ready, f_p1_rvalid, f_mem_command;
  logic [1:0] f_p0_rdata, f_p1_rdata;
  logic [5:0] f_mem_address;
  wire  [1:0] f_mem_data;

  maze_mem_arbiter #(.FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_ready(p0_ready),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_command(mem_command), .mem_data(mem_data)
  );

  maze_mem_arbiter #(.FIXED_PRIO(1)) u_dut_fx (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_ready(f_p0_ready),
    .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(f_p1_ready), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
    .mem_address(f_mem_address), .mem_command(f_mem_command), .mem_data(f_mem_data)
  );

  // Memory devices on each bus: drive when commanded to read, commit writes at the edge.
  logic [1:0] dev_mem [64];
  logic [1:0] f_dev_mem [64];
  logic [1:0] init_val [64];
  logic       mem_init;

  assign mem_data   = mem_command   ? dev_mem[mem_address]     : 2'bzz;
  assign f_mem_data = f_mem_command ? f_dev_mem[f_mem_address] : 2'bzz;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        dev_mem[i]   <= init_val[i];
        f_dev_mem[i] <= init_val[i];
      end
    end else begin
      if (!mem_command)   dev_mem[mem_address]     <= mem_data;
      if (!f_mem_command) f_dev_mem[f_mem_address] <= f_mem_data;
    end
  end

  // Reference model state.
  logic [1:0] ref_mem [64];
  bit         m_last;   // port granted most recently
  bit         m_turn;   // bus turnaround pending this cycle
  bit         fx_on;    // also check the fixed-priority instance's grants

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_turn = 1'b0;
  endtask

  // One clock of traffic. Entered just after a rising edge; leaves 1 ns after the next.
  task automatic step(input bit v0, input logic [5:0] a0, input bit v1, input bit we,
                      input logic [5:0] a1, input logic [1:0] wd,
                      output bit g0, output bit g1);
    logic [1:0] rd0, rd1;
    p0_valid = v0; p0_addr = a0;
    p1_valid = v1; p1_we = we; p1_addr = a1; p1_wdata = wd;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_turn) begin
      if (v0 && v1) begin
        g0 = (m_last == 1'b1);
        g1 = !g0;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    @(negedge clk);
    chk("p0_ready", 8'(p0_ready), 8'(g0));
    chk("p1_ready", 8'(p1_ready), 8'(g1));
    chk("mem_command", 8'(mem_command), 8'(!(g1 && we)));
    if (g0) begin
      chk("addr_p0", 8'(mem_address), 8'(a0));
      chk("bus_rd_p0", 8'(mem_data), 8'(ref_mem[a0]));
    end
    if (g1) chk("addr_p1", 8'(mem_address), 8'(a1));
    if (g1 && !we) chk("bus_rd_p1", 8'(mem_data), 8'(ref_mem[a1]));
    if (g1 && we) chk("bus_wr", 8'(mem_data), 8'(wd));
    if (fx_on) begin
      chk("fx_p0_ready", 8'(f_p0_ready), 8'(v0));
      chk("fx_p1_ready", 8'(f_p1_ready), 8'(v1 && !v0));
    end
    rd0 = ref_mem[a0];
    rd1 = ref_mem[a1];
    @(posedge clk);
    #1;
    if (g1 && we) ref_mem[a1] = wd;
    if (g0) m_last = 1'b0;
    else if (g1) m_last = 1'b1;
    m_turn = g1 && we;
    chk("p0_rvalid", 8'(p0_rvalid), 8'(g0));
    chk("p1_rvalid", 8'(p1_rvalid), 8'(g1 && !we));
    if (g0) chk("p0_rdata", 8'(p0_rdata), 8'(rd0));
    if (g1 && !we) chk("p1_rdata", 8'(p1_rdata), 8'(rd1));
  endtask

  initial begin
    bit g0, g1, pg0;
    bit pend0, pend1, pwe;
    logic [5:0] pa0, pa1;
    logic [1:0] pwd;

    fx_on = 1'b0;
    rst_n = 1'b0;
    p0_valid = 1'b0; p0_addr = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < 64; i++) init_val[i] = 2'($urandom_range(0, 2));
    init_val[0]  = 2'd0;
    init_val[48] = 2'd2;
    init_val[12] = 2'd2;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val[i];
    mem_init = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    #1;
    chk("rst_p0_ready", 8'(p0_ready), 8'd0);
    chk("rst_p1_ready", 8'(p1_ready), 8'd0);
    chk("rst_p0_rvalid", 8'(p0_rvalid), 8'd0);
    chk("rst_p1_rvalid", 8'(p1_rvalid), 8'd0);
    chk("rst_p0_rdata", 8'(p0_rdata), 8'd0);
    chk("rst_p1_rdata", 8'(p1_rdata), 8'd0);
    chk("rst_mem_command", 8'(mem_command), 8'd1);
    chk("rst_mem_address", 8'(mem_address), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lone p0 read of the goal cell.
    step(1, 6'd48, 0, 0, 6'd0, 2'd0, g0, g1);
    chk("t2_grant", 8'(g0), 8'd1);
    chk("t2_rdata_goal", 8'(p0_rdata), 8'd2);

    // Reset during a write grant with a read return in flight.
    step(1, 6'd5, 0, 0, 6'd0, 2'd0, g0, g1);
    p0_valid = 1'b0;
    p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 6'd7; p1_wdata = 2'd3;
    #3;
    chk("t1_write_cmd", 8'(mem_command), 8'd0);
    rst_n = 1'b0;
    #1;
    chk("t1_cmd_async", 8'(mem_command), 8'd1);
    chk("t1_bus_released", 8'(mem_data), 8'(dev_mem[0]));
    chk("t1_addr", 8'(mem_address), 8'd0);
    chk("t1_rvalid_drop", 8'(p0_rvalid), 8'd0);
    chk("t1_p1_ready", 8'(p1_ready), 8'd0);
    p1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("t1_no_replay", 8'(p0_rvalid), 8'd0);

    // Both ports read for four cycles: grants alternate starting with port 0.
    for (int k = 0; k < 4; k++) begin
      step(1, 6'($urandom), 1, 0, 6'($urandom), 2'd0, g0, g1);
      if (k == 0) chk("t3_first_p0", 8'(g0), 8'd1);
      else chk("t3_alternate", 8'(g0), 8'(!pg0));
      pg0 = g0;
    end

    // Write then read-after-write through the turnaround cycle.
    step(0, 6'd0, 1, 1, 6'd12, 2'd1, g0, g1);
    chk("t4_wr_grant", 8'(g1), 8'd1);
    step(0, 6'd0, 1, 0, 6'd12, 2'd0, g0, g1);
    chk("t4_turn_no_grant", 8'(g1), 8'd0);
    chk("t4_turn_cmd", 8'(mem_command), 8'd1);
    step(0, 6'd0, 1, 0, 6'd12, 2'd0, g0, g1);
    chk("t4_rd_grant", 8'(g1), 8'd1);
    chk("t4_raw_data", 8'(p1_rdata), 8'd1);

    // p1 write competing with p0 read; p0 waits until after the turnaround.
    step(1, 6'd20, 0, 0, 6'd0, 2'd0, g0, g1);
    step(1, 6'd21, 1, 1, 6'd30, 2'd3, g0, g1);
    chk("t6_wr_wins", 8'(g1), 8'd1);
    step(1, 6'd21, 0, 0, 6'd0, 2'd0, g0, g1);
    chk("t6_turn_p0_wait", 8'(g0), 8'd0);
    step(1, 6'd21, 0, 0, 6'd0, 2'd0, g0, g1);
    chk("t6_p0_after_turn", 8'(g0), 8'd1);

    // Fixed priority: p1 starved while p0 stays valid.
    step(0, 6'd0, 0, 0, 6'd0, 2'd0, g0, g1);
    step(0, 6'd0, 0, 0, 6'd0, 2'd0, g0, g1);
    fx_on = 1'b1;
    for (int k = 0; k < 4; k++) step(1, 6'($urandom), 1, 0, 6'd9, 2'd0, g0, g1);
    step(0, 6'd0, 1, 0, 6'd9, 2'd0, g0, g1);
    fx_on = 1'b0;

    // Randomized traffic with valid held until accepted.
    pend0 = 1'b0; pend1 = 1'b0;
    pa0 = '0; pa1 = '0; pwe = 1'b0; pwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend0 && ($urandom_range(0, 2) != 0)) begin
        pend0 = 1'b1;
        pa0 = 6'($urandom);
      end
      if (!pend1 && ($urandom_range(0, 2) != 0)) begin
        pend1 = 1'b1;
        pwe = 1'($urandom);
        pa1 = 6'($urandom_range(0, 15));
        pwd = 2'($urandom_range(0, 2));
      end
      step(pend0, pa0, pend1, pwe, pa1, pwd, g0, g1);
      if (g0) pend0 = 1'b0;
      if (g1) pend1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
